// File: rtl/task_graph_mapper_if.sv
// ---------------------------------------------------------------------------
// task_graph_mapper_if
//   Groups the control, adjacency-load and mapping-result signals of
//   task_graph_mapper.
//   slave  : the mapper side (consumes matrix entries, produces mappings)
//   master : the environment side (feeds entries, consumes mappings)
//   Signals: start, in_valid/in_ready/in_weight (load stream),
//            root_task/root_id (root report),
//            map_valid/map_ready/map_task/map_pe/map_iso/map_load (results),
//            done, err.
// ---------------------------------------------------------------------------
interface task_graph_mapper_if #(
    parameter int NUM_V  = 4,
    parameter int W      = 32,
    parameter int NUM_PE = 4
);
    localparam int VW = $clog2(NUM_V);
    localparam int PW = $clog2(NUM_PE);
    localparam int LW = W + 2 * VW;

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_weight;
    logic          root_task;
    logic [VW-1:0] root_id;
    logic          map_valid;
    logic          map_ready;
    logic [VW-1:0] map_task;
    logic [PW-1:0] map_pe;
    logic          map_iso;
    logic [LW-1:0] map_load;
    logic          done;
    logic          err;

    modport slave (
        input  start, in_valid, in_weight, map_ready,
        output in_ready, root_task, root_id, map_valid, map_task, map_pe,
               map_iso, map_load, done, err
    );

    modport master (
        output start, in_valid, in_weight, map_ready,
        input  in_ready, root_task, root_id, map_valid, map_task, map_pe,
               map_iso, map_load, done, err
    );
endinterface

// File: rtl/task_graph_mapper.sv
// ---------------------------------------------------------------------------
// task_graph_mapper
//   Loads a NUM_V x NUM_V adjacency matrix (row-major, 0 = no edge), finds
//   the root task (row of the first nonzero entry), then maps every task in
//   index order onto the least-loaded processing element. Tasks without
//   edges are reported isolated and do not consume PE capacity.
//
//   Ports:
//     clk       - clock, rising edge
//     rst_b     - asynchronous active-low reset
//     bus       - task_graph_mapper_if.slave (load stream, root report,
//                 mapping results, done pulse, sticky err)
//     dbg_state - current FSM state (0 IDLE, 1 LOAD, 2 MAP, 3 DONE)
//
//   Build option: define TGM_SELF_LOOP_CHECK_EN to flag nonzero diagonal
//   entries on err and drop them from sums, degrees and root detection.
//
//   Handshakes: a beat moves on a rising edge where valid & ready are both
//   high; the producer keeps valid and payload stable until that edge and
//   valid never depends on ready.
// ---------------------------------------------------------------------------
module task_graph_mapper #(
    parameter int NUM_V  = 4,
    parameter int W      = 32,
    parameter int NUM_PE = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    task_graph_mapper_if.slave   bus,
    output logic [1:0]           dbg_state
);
    localparam int VW = $clog2(NUM_V);
    localparam int PW = $clog2(NUM_PE);
    localparam int LW = W + 2 * VW;
    localparam int DW = $clog2(NUM_V + 1);
    localparam logic [VW-1:0] LAST_V = VW'(NUM_V - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MAP = 2'd2, DONE = 2'd3} state_t;

    state_t        state, state_nx;
    logic [VW-1:0] row, col, map_idx;
    logic [LW-1:0] task_sum [NUM_V];
    logic [DW-1:0] deg      [NUM_V];
    logic [LW-1:0] pe_load  [NUM_PE];
    logic          root_found;
    logic          root_task_q, err_q;
    logic [VW-1:0] root_id_q;

    logic          in_ready_i, map_valid_i;
    logic          accept, xfer, last_entry, entry_nz, self_loop, entry_counts;
    logic [LW-1:0] add_w, best_load;
    logic [PW-1:0] best_pe;
    logic          cur_iso;

    assign accept     = bus.in_valid & in_ready_i;
    assign xfer       = map_valid_i & bus.map_ready;
    assign last_entry = (row == LAST_V) && (col == LAST_V);
    assign entry_nz   = (bus.in_weight != '0);
`ifdef TGM_SELF_LOOP_CHECK_EN
    assign self_loop  = entry_nz && (row == col);
`else
    assign self_loop  = 1'b0;
`endif
    assign entry_counts = entry_nz && !self_loop;
    assign add_w        = self_loop ? '0 : LW'(bus.in_weight);
    assign cur_iso      = (deg[map_idx] == '0);

    // Least-loaded PE; strict compare keeps the lowest index on ties.
    always_comb begin
        best_pe   = '0;
        best_load = pe_load[0];
        for (int i = 1; i < NUM_PE; i++) begin
            if (pe_load[i] < best_load) begin
                best_load = pe_load[i];
                best_pe   = PW'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start)                   state_nx = LOAD;
            LOAD: if (accept && last_entry)        state_nx = MAP;
            MAP:  if (xfer && map_idx == LAST_V)   state_nx = DONE;
            DONE:                                  state_nx = IDLE;
            default:                               state_nx = IDLE;
        endcase
    end

    // Output logic; mapping fields are forced to zero outside MAP.
    always_comb begin
        in_ready_i   = (state == LOAD);
        map_valid_i  = (state == MAP);
        bus.done     = (state == DONE);
        bus.map_task = map_valid_i ? map_idx : '0;
        bus.map_pe   = (map_valid_i && !cur_iso) ? best_pe : '0;
        bus.map_iso  = map_valid_i && cur_iso;
        bus.map_load = map_valid_i ? task_sum[map_idx] : '0;
    end

    assign bus.in_ready  = in_ready_i;
    assign bus.map_valid = map_valid_i;
    assign bus.root_task = root_task_q;
    assign bus.root_id   = root_id_q;
    assign bus.err       = err_q;
    assign dbg_state     = state;

    // Datapath: matrix counters, per-task accumulation, PE loads.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            row         <= '0;
            col         <= '0;
            map_idx     <= '0;
            root_found  <= 1'b0;
            root_task_q <= 1'b0;
            root_id_q   <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < NUM_V; i++) begin
                task_sum[i] <= '0;
                deg[i]      <= '0;
            end
            for (int i = 0; i < NUM_PE; i++) pe_load[i] <= '0;
        end else begin
            root_task_q <= 1'b0;
            if (state == IDLE && bus.start) begin
                row        <= '0;
                col        <= '0;
                map_idx    <= '0;
                root_found <= 1'b0;
                root_id_q  <= '0;
                err_q      <= 1'b0;
                for (int i = 0; i < NUM_V; i++) begin
                    task_sum[i] <= '0;
                    deg[i]      <= '0;
                end
                for (int i = 0; i < NUM_PE; i++) pe_load[i] <= '0;
            end
            if (accept) begin
                task_sum[row] <= task_sum[row] + add_w;
                if (entry_counts) deg[row] <= deg[row] + DW'(1);
                if (entry_counts && !root_found) begin
                    root_found  <= 1'b1;
                    root_id_q   <= row;
                    root_task_q <= 1'b1;
                end
                if (self_loop) err_q <= 1'b1;
                if (last_entry) begin
                    row <= '0;
                    col <= '0;
                end else if (col == LAST_V) begin
                    col <= '0;
                    row <= row + VW'(1);
                end else begin
                    col <= col + VW'(1);
                end
            end
            if (xfer) begin
                if (!cur_iso) pe_load[best_pe] <= pe_load[best_pe] + task_sum[map_idx];
                map_idx <= (map_idx == LAST_V) ? '0 : map_idx + VW'(1);
            end
        end
    end
endmodule

// File: tb/tb_task_graph_mapper.sv
module tb_task_graph_mapper;
    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] dbg_a, dbg_b;

    // a: 3 tasks on 2 PEs; b: 4 tasks on 4 PEs
    task_graph_mapper_if #(.NUM_V(3), .W(32), .NUM_PE(2)) a_if ();
    task_graph_mapper_if #(.NUM_V(4), .W(32), .NUM_PE(4)) b_if ();

    task_graph_mapper #(.NUM_V(3), .W(32), .NUM_PE(2)) dut_a (
        .clk(clk), .rst_b(rst_b), .bus(a_if), .dbg_state(dbg_a));
    task_graph_mapper #(.NUM_V(4), .W(32), .NUM_PE(4)) dut_b (
        .clk(clk), .rst_b(rst_b), .bus(b_if), .dbg_state(dbg_b));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mat [16];
    logic [63:0] exp_q [$];
    logic [63:0] obs_a [$];
    logic [63:0] obs_b [$];
    int          roots_a = 0, acc_a = 0, root_at_a = -1, dones_a = 0;
    int          roots_b = 0, dones_b = 0;
    int          stall_seen_a = 0, stall_bad_a = 0;
    bit          held_a = 1'b0;
    logic [63:0] held_val_a = '0, cur_a, cur_b;
    bit          seen;

    function automatic logic [63:0] pack(input int t, input int p, input int iso, input longint ld);
        return {8'(t), 8'(p), 8'(iso), 40'(ld)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_if.start && dbg_a == 2'd0) begin
            obs_a.delete();
            roots_a = 0; acc_a = 0; root_at_a = -1; dones_a = 0;
        end
        if (a_if.root_task) begin
            roots_a++;
            root_at_a = acc_a;
        end
        if (a_if.in_valid && a_if.in_ready) acc_a++;
        cur_a = pack(int'(a_if.map_task), int'(a_if.map_pe), int'(a_if.map_iso), longint'(a_if.map_load));
        if (held_a && a_if.map_valid) begin
            stall_seen_a++;
            if (cur_a !== held_val_a) stall_bad_a++;
        end
        held_a     = a_if.map_valid && !a_if.map_ready;
        held_val_a = cur_a;
        if (a_if.map_valid && a_if.map_ready) obs_a.push_back(cur_a);
        if (a_if.done) dones_a++;
    end

    always @(negedge clk) begin
        if (b_if.start && dbg_b == 2'd0) begin
            obs_b.delete();
            roots_b = 0; dones_b = 0;
        end
        if (b_if.root_task) roots_b++;
        cur_b = pack(int'(b_if.map_task), int'(b_if.map_pe), int'(b_if.map_iso), longint'(b_if.map_load));
        if (b_if.map_valid && b_if.map_ready) obs_b.push_back(cur_b);
        if (b_if.done) dones_b++;
    end

    // ---------------- driver tasks (called at posedge + #1) ----------------
    task automatic do_start(input bit sel);
        if (sel) b_if.start = 1'b1; else a_if.start = 1'b1;
        @(posedge clk); #1;
        a_if.start = 1'b0;
        b_if.start = 1'b0;
    endtask

    task automatic feed(input bit sel, input bit gapped, input int limit);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < limit && cyc < 500) begin
            if (sel) begin
                b_if.in_valid  = !(gapped && (cyc % 2 == 1));
                b_if.in_weight = mat[idx];
            end else begin
                a_if.in_valid  = !(gapped && (cyc % 2 == 1));
                a_if.in_weight = mat[idx];
            end
            @(negedge clk);
            acc = sel ? (b_if.in_valid && b_if.in_ready) : (a_if.in_valid && a_if.in_ready);
            if (acc) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        a_if.in_valid = 1'b0;
        b_if.in_valid = 1'b0;
        check("feed_count", 64'(idx), 64'(limit));
    endtask

    task automatic drain(input bit sel, input bit toggle, output bit got_done);
        int cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (sel) b_if.map_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            else     a_if.map_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            @(negedge clk);
            if (sel ? b_if.done : a_if.done) got_done = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        a_if.map_ready = 1'b0;
        b_if.map_ready = 1'b0;
    endtask

    task automatic compare_maps(input bit sel, input string tag);
        int n_obs;
        n_obs = sel ? obs_b.size() : obs_a.size();
        check({tag, "_count"}, 64'(n_obs), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_obs) check(tag, sel ? obs_b[i] : obs_a[i], exp_q[i]);
        end
    endtask

    task automatic load_chain3();
        mat = '{0, 5, 0, 5, 0, 6, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_q.delete();
        exp_q.push_back(pack(0, 0, 0, 5));
        exp_q.push_back(pack(1, 1, 0, 11));
        exp_q.push_back(pack(2, 0, 0, 6));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        a_if.start = 1'b0; a_if.in_valid = 1'b0; a_if.in_weight = '0; a_if.map_ready = 1'b0;
        b_if.start = 1'b0; b_if.in_valid = 1'b0; b_if.in_weight = '0; b_if.map_ready = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_state", 64'(dbg_a), 64'(0));
        check("rst_in_ready", 64'(a_if.in_ready), 64'(0));
        check("rst_map_valid", 64'(a_if.map_valid), 64'(0));
        check("rst_done_err", 64'({a_if.done, a_if.err, a_if.root_task}), 64'(0));
        check("rst_root_id", 64'(a_if.root_id), 64'(0));
        check("rst_map_load", 64'(b_if.map_load), 64'(0));
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;

        // chain graph, free-flowing
        load_chain3();
        do_start(1'b0);
        check("load_in_ready", 64'(a_if.in_ready), 64'(1));
        feed(1'b0, 1'b0, 9);
        check("first_valid", 64'(a_if.map_valid), 64'(1));
        drain(1'b0, 1'b0, seen);
        check("chain_done_seen", 64'(seen), 64'(1));
        check("chain_done_once", 64'(dones_a), 64'(1));
        check("chain_root_pulses", 64'(roots_a), 64'(1));
        check("chain_root_after", 64'(root_at_a), 64'(2));
        check("chain_root_id", 64'(a_if.root_id), 64'(0));
        check("chain_err", 64'(a_if.err), 64'(0));
        compare_maps(1'b0, "chain_map");

        // chain graph, gapped input and stalling consumer
        load_chain3();
        do_start(1'b0);
        feed(1'b0, 1'b1, 9);
        drain(1'b0, 1'b1, seen);
        check("stall_done_seen", 64'(seen), 64'(1));
        check("stall_root_after", 64'(root_at_a), 64'(2));
        check("stall_root_id", 64'(a_if.root_id), 64'(0));
        compare_maps(1'b0, "stall_map");
        check("stall_exercised", 64'(stall_seen_a != 0), 64'(1));
        check("stall_stable", 64'(stall_bad_a), 64'(0));

        // reset in the middle of a load
        mat = '{0, 0, 0, 4, 4, 4, 4, 4, 4, 0, 0, 0, 0, 0, 0, 0};
        do_start(1'b0);
        feed(1'b0, 1'b0, 5);
        check("pre_rst_root_id", 64'(a_if.root_id), 64'(1));
        rst_b = 1'b0;
        @(negedge clk);
        check("midrst_state", 64'(dbg_a), 64'(0));
        check("midrst_root_id", 64'(a_if.root_id), 64'(0));
        check("midrst_in_ready", 64'(a_if.in_ready), 64'(0));
        @(posedge clk); #1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(dbg_a), 64'(0));
        load_chain3();
        do_start(1'b0);
        feed(1'b0, 1'b0, 9);
        drain(1'b0, 1'b0, seen);
        check("rerun_done_seen", 64'(seen), 64'(1));
        check("rerun_root_after", 64'(root_at_a), 64'(2));
        compare_maps(1'b0, "rerun_map");

        // all-zero 4x4 matrix
        mat = '{default: 0};
        exp_q.delete();
        for (int t = 0; t < 4; t++) exp_q.push_back(pack(t, 0, 1, 0));
        do_start(1'b1);
        feed(1'b1, 1'b0, 16);
        drain(1'b1, 1'b0, seen);
        check("zero_done_seen", 64'(seen), 64'(1));
        check("zero_root_pulses", 64'(roots_b), 64'(0));
        check("zero_root_id", 64'(b_if.root_id), 64'(0));
        compare_maps(1'b1, "zero_map");

        // single edge from task 2, plus a start during MAP
        mat = '{0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0};
        exp_q.delete();
        exp_q.push_back(pack(0, 0, 1, 0));
        exp_q.push_back(pack(1, 0, 1, 0));
        exp_q.push_back(pack(2, 0, 0, 7));
        exp_q.push_back(pack(3, 0, 1, 0));
        do_start(1'b1);
        feed(1'b1, 1'b0, 16);
        b_if.start = 1'b1;
        @(posedge clk); #1;
        b_if.start = 1'b0;
        check("start_ignored", 64'(dbg_b), 64'(2));
        drain(1'b1, 1'b0, seen);
        check("row2_done_seen", 64'(seen), 64'(1));
        check("row2_root_pulses", 64'(roots_b), 64'(1));
        check("row2_root_id", 64'(b_if.root_id), 64'(2));
        compare_maps(1'b1, "row2_map");

        // diagonal entry (1,1)=9
        mat = '{0, 0, 0, 0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_q.delete();
        exp_q.push_back(pack(0, 0, 1, 0));
`ifdef TGM_SELF_LOOP_CHECK_EN
        exp_q.push_back(pack(1, 0, 0, 2));
`else
        exp_q.push_back(pack(1, 0, 0, 11));
`endif
        exp_q.push_back(pack(2, 0, 1, 0));
        do_start(1'b0);
        feed(1'b0, 1'b0, 9);
        drain(1'b0, 1'b0, seen);
        check("diag_done_seen", 64'(seen), 64'(1));
        check("diag_root_id", 64'(a_if.root_id), 64'(1));
`ifdef TGM_SELF_LOOP_CHECK_EN
        check("diag_err", 64'(a_if.err), 64'(1));
        check("diag_root_after", 64'(root_at_a), 64'(6));
`else
        check("diag_err", 64'(a_if.err), 64'(0));
        check("diag_root_after", 64'(root_at_a), 64'(5));
`endif
        compare_maps(1'b0, "diag_map");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/task_graph_mapper.md
TASK_GRAPH_MAPPER -- requirements
Module: task_graph_mapper

Interface
REQ-001 Parameter NUM_V, default 4, is the number of task-graph vertices (tasks); legal range 2..16.
REQ-002 Parameter W, default 32, is the edge-weight width.
REQ-003 Parameter NUM_PE, default 4, is the number of processing elements; legal range 2..8.
REQ-004 Derived widths: VW=$clog2(NUM_V), PW=$clog2(NUM_PE), LW=W+2*VW.
REQ-005 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 Port rst_b, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port start, input, 1 bit: begins a new graph load; honoured only in IDLE.
REQ-008 Port in_valid, input, 1 bit: in_weight is valid.
REQ-009 Port in_ready, output, 1 bit: block accepts an entry; accept = in_valid & in_ready.
REQ-010 Port in_weight, input, W bits: adjacency-matrix entry; row-major order; 0 means no edge.
REQ-011 Port root_task, output, 1 bit: one-cycle pulse when the root task is identified.
REQ-012 Port root_id, output, VW bits: root task index; valid from the root_task pulse until the next start.
REQ-013 Port map_valid, output, 1 bit; map_ready, input, 1 bit: mapping-result handshake.
REQ-014 Port map_task, output, VW bits; map_pe, output, PW bits; map_iso, output, 1 bit; map_load, output, LW bits: task index, assigned PE, isolated flag, and the task's row weight sum.
REQ-015 Port done, output, 1 bit: one-cycle pulse after the last mapping transfers.
REQ-016 Port err, output, 1 bit: sticky error flag; cleared by start or reset.

Function
REQ-017 FSM states: IDLE, LOAD, MAP, DONE; IDLE->LOAD on start; LOAD->MAP after NUM_V*NUM_V accepts; MAP->DONE after NUM_V map transfers; DONE->IDLE unconditionally after one cycle.
REQ-018 On IDLE->LOAD: clear row/column counters, per-task sums and degrees, per-PE loads, root-found flag, root_id, and err.
REQ-019 in_ready=1 only in LOAD; one entry is accepted per cycle, with no bubbles required.
REQ-020 Per accepted entry at (row r, column c): task_sum[r] += in_weight (LW bits, no overflow possible); if in_weight!=0, then deg[r]++.
REQ-021 Counters: c wraps NUM_V-1->0 and then r increments; the final accept is at r=c=NUM_V-1.
REQ-022 Root = row of the first accepted nonzero entry; root_id is loaded and root_task pulses on the cycle after that accept; it occurs at most once per graph.
REQ-023 Matrix with no nonzero entry: root_task never pulses, root_id stays 0, and all tasks are reported isolated.
REQ-024 MAP emits tasks in index order 0..NUM_V-1; each output is held stable while map_valid & !map_ready.
REQ-025 Task with deg=0: map_iso=1, map_pe=0, and no PE load is updated.
REQ-026 Other tasks: map_pe = PE with minimum pe_load, ties to the lowest index; on transfer, pe_load[map_pe] += task_sum.
REQ-027 The first map_valid is asserted the cycle after entering MAP; the next task is presented the cycle after each transfer.
REQ-028 start outside IDLE is ignored.

Reset
REQ-029 While rst_b=0: state=IDLE; in_ready, root_task, map_valid, done, and err =0; root_id, map_task, map_pe, map_iso, and map_load =0; all counters, sums, and loads =0.
REQ-030 Reset mid-LOAD or mid-MAP discards the graph; after release, the block waits in IDLE for start.

Configuration
REQ-031 Macro TGM_SELF_LOOP_CHECK_EN defined: a nonzero diagonal entry (r==c) sets err and is excluded from task_sum, deg, and root detection.
REQ-032 Macro TGM_SELF_LOOP_CHECK_EN undefined: diagonal entries are treated like any other entry, and err stays 0.

Verification
REQ-033 NUM_V=3, NUM_PE=2, matrix {0,5,0 / 5,0,6 / 0,6,0}, map_ready=1 -> root_task pulses after the 2nd accept with root_id=0; maps (0,PE0,5), (1,PE1,11), (2,PE0,6); done pulses.
REQ-034 NUM_V=4, all-zero matrix -> no root_task; 4 maps with map_iso=1, map_pe=0; done pulses.
REQ-035 Same as REQ-033 with map_ready toggling 0/1 each cycle and in_valid gapped every 2 cycles -> identical results; outputs stable during stalls.
REQ-036 NUM_V=4, rows 0-1 zero, row 2 = {7,0,0,0} -> root_id=2; tasks 0,1,3 isolated; task 2 on PE0 with load 7.
REQ-037 rst_b=0 asserted mid-LOAD after 5 accepts, then a fresh start and the REQ-033 matrix -> results identical to REQ-033.
REQ-038 With TGM_SELF_LOOP_CHECK_EN defined, entry (1,1)=9 -> err=1 and task 1 sum excludes 9; without the macro, err=0 and the sum includes 9.
